id_stage_pipelined: RTL

//  ARM instruction-decode stage with integrated ID/EX pipeline register.
//  - Decodes the condition, control and operand fields; reads the register file with write-back bypass.
//  - Detects RAW hazards against the EX and MEM stages and issues stall or bubble.
//  - Registers all EX-bound signals, so downstream sees them 1 cycle after the instruction is presented.

---
 rtl/id_stage_pipelined.sv | 321 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipelined.sv
// ARM instruction-decode stage: condition and control decode, a register file
// with write-back bypass, RAW hazard detection and the ID/EX pipeline register.
module id_stage_pipelined #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 16,
  parameter bit HAZARD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  input  logic [31:0]       pc_in,
  input  logic              n,
  input  logic              z,
  input  logic              c,
  input  logic              v,
  input  logic              freeze,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic [3:0]        exe_dest,
  input  logic              exe_wb_en,
  input  logic [3:0]        mem_dest,
  input  logic              mem_wb_en,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic              ex_wb_en,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_s,
  output logic              ex_branch,
  output logic              ex_imm,
  output logic [3:0]        ex_cmd,
  output logic [DATA_W-1:0] ex_val_rn,
  output logic [DATA_W-1:0] ex_val_rm,
  output logic [11:0]       ex_shift_op,
  output logic [23:0]       ex_simm24,
  output logic [3:0]        ex_dest,
  output logic [3:0]        ex_src1,
  output logic [3:0]        ex_src2,
  output logic [31:0]       ex_pc
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] CMD_MEM  = 4'b0010;

  typedef struct packed {
    logic              valid;
    logic              wb_en;
    logic              mem_read;
    logic              mem_write;
    logic              s;
    logic              branch;
    logic              imm;
    logic [3:0]        cmd;
    logic [DATA_W-1:0] val_rn;
    logic [DATA_W-1:0] val_rm;
    logic [11:0]       shift_op;
    logic [23:0]       simm24;
    logic [3:0]        dest;
    logic [3:0]        src1;
    logic [3:0]        src2;
    logic [31:0]       pc;
  } ex_t;

  // Returns {defined, writes_back, alu_cmd} for a data-processing opcode.
  function automatic logic [5:0] dp_decode(input logic [3:0] opcode);
    logic [5:0] r;
    case (opcode)
      OP_MOV:  r = {1'b1, 1'b1, 4'b0001};
      OP_MVN:  r = {1'b1, 1'b1, 4'b1001};
      OP_ADD:  r = {1'b1, 1'b1, 4'b0010};
      OP_ADC:  r = {1'b1, 1'b1, 4'b0011};
      OP_SUB:  r = {1'b1, 1'b1, 4'b0100};
      OP_SBC:  r = {1'b1, 1'b1, 4'b0101};
      OP_AND:  r = {1'b1, 1'b1, 4'b0110};
      OP_ORR:  r = {1'b1, 1'b1, 4'b0111};
      OP_EOR:  r = {1'b1, 1'b1, 4'b1000};
      OP_CMP:  r = {1'b1, 1'b0, 4'b0100};
      OP_TST:  r = {1'b1, 1'b0, 4'b0110};
      default: r = 6'b000000;
    endcase
    return r;
  endfunction

  function automatic logic cond_check(input logic [3:0] cond, input logic fn,
                                      input logic fz, input logic fc, input logic fv);
    logic r;
    case (cond)
      4'b0000: r = fz;
      4'b0001: r = ~fz;
      4'b0010: r = fc;
      4'b0011: r = ~fc;
      4'b0100: r = fn;
      4'b0101: r = ~fn;
      4'b0110: r = fv;
      4'b0111: r = ~fv;
      4'b1000: r = fc & ~fz;
      4'b1001: r = ~fc | fz;
      4'b1010: r = (fn == fv);
      4'b1011: r = (fn != fv);
      4'b1100: r = ~fz & (fn == fv);
      4'b1101: r = fz | (fn != fv);
      4'b1110: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [DATA_W-1:0] rf_r [NUM_REGS];
  ex_t               ex_r;
  ex_t               ex_nxt_s;

  logic [1:0]        mode_s;
  logic [3:0]        opcode_s;
  logic              sbit_s;
  logic              imm_s;
  logic              cond_pass_s;
  logic [5:0]        dp_dec_s;
  logic              is_str_s;
  logic [3:0]        src1_s;
  logic [3:0]        src2_s;
  logic [3:0]        dest_s;
  logic [DATA_W-1:0] rn_val_s;
  logic [DATA_W-1:0] rm_val_s;
  logic              uses_rn_s;
  logic              uses_rm_s;
  logic              rn_busy_s;
  logic              rm_busy_s;
  logic              hazard_s;
  logic              issue_s;
  logic [3:0]        ctl_cmd_s;
  logic              ctl_wb_s;
  logic              ctl_mr_s;
  logic              ctl_mw_s;
  logic              ctl_br_s;
  logic              ctl_s_s;

  assign mode_s      = instr[27:26];
  assign imm_s       = instr[25];
  assign opcode_s    = instr[24:21];
  assign sbit_s      = instr[20];
  assign cond_pass_s = cond_check(instr[31:28], n, z, c, v);
  assign dp_dec_s    = dp_decode(opcode_s);

  // STR carries its store data in the Rd field, so that becomes the second source.
  assign is_str_s = (mode_s == MODE_MEM) && !sbit_s;
  assign src1_s   = instr[19:16];
  assign src2_s   = is_str_s ? instr[15:12] : instr[3:0];
  assign dest_s   = instr[15:12];

  // Control unit: ALU command and stage enables from mode and opcode.
  always_comb begin
    ctl_cmd_s = 4'b0000;
    ctl_wb_s  = 1'b0;
    ctl_mr_s  = 1'b0;
    ctl_mw_s  = 1'b0;
    ctl_br_s  = 1'b0;
    ctl_s_s   = 1'b0;
    case (mode_s)
      MODE_DP: begin
        ctl_cmd_s = dp_dec_s[3:0];
        ctl_wb_s  = dp_dec_s[4];
        ctl_s_s   = dp_dec_s[5] & sbit_s;
      end
      MODE_MEM: begin
        ctl_cmd_s = CMD_MEM;
        ctl_mr_s  = sbit_s;
        ctl_wb_s  = sbit_s;
        ctl_mw_s  = ~sbit_s;
      end
      MODE_BR: begin
        ctl_br_s  = 1'b1;
      end
      default: begin
        ctl_cmd_s = 4'b0000;
      end
    endcase
  end

  // Register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf_r[i] <= '0;
    end else if (wb_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_dest == 4'(i)) rf_r[i] <= wb_value;
      end
    end
  end

  // Register-file read ports; a same-cycle write-back wins over the stored value.
  always_comb begin
    rn_val_s = '0;
    rm_val_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rn_val_s = (src1_s == 4'(i)) ? rf_r[i] : rn_val_s;
      rm_val_s = (src2_s == 4'(i)) ? rf_r[i] : rm_val_s;
    end
    rn_val_s = (wb_en && wb_dest == src1_s) ? wb_value : rn_val_s;
    rm_val_s = (wb_en && wb_dest == src2_s) ? wb_value : rm_val_s;
  end

  assign uses_rn_s = ((mode_s == MODE_DP) && (opcode_s != OP_MOV) && (opcode_s != OP_MVN))
                   || (mode_s == MODE_MEM);
  assign uses_rm_s = ((mode_s == MODE_DP) && !imm_s) || is_str_s;
  assign rn_busy_s = (exe_wb_en && exe_dest == src1_s) || (mem_wb_en && mem_dest == src1_s);
  assign rm_busy_s = (exe_wb_en && exe_dest == src2_s) || (mem_wb_en && mem_dest == src2_s);

  assign hazard_s = HAZARD_EN && instr_valid && cond_pass_s
                  && ((uses_rn_s && rn_busy_s) || (uses_rm_s && rm_busy_s));
  assign hazard_stall = hazard_s;
  assign issue_s = instr_valid && cond_pass_s && !hazard_s;

  // Next ID/EX contents: decoded instruction, or an all-zero bubble.
  always_comb begin
    ex_nxt_s = '0;
    if (issue_s && !flush) begin
      ex_nxt_s.valid     = 1'b1;
      ex_nxt_s.wb_en     = ctl_wb_s;
      ex_nxt_s.mem_read  = ctl_mr_s;
      ex_nxt_s.mem_write = ctl_mw_s;
      ex_nxt_s.s         = ctl_s_s;
      ex_nxt_s.branch    = ctl_br_s;
      ex_nxt_s.imm       = imm_s;
      ex_nxt_s.cmd       = ctl_cmd_s;
      ex_nxt_s.val_rn    = rn_val_s;
      ex_nxt_s.val_rm    = rm_val_s;
      ex_nxt_s.shift_op  = instr[11:0];
      ex_nxt_s.simm24    = instr[23:0];
      ex_nxt_s.dest      = dest_s;
      ex_nxt_s.src1      = src1_s;
      ex_nxt_s.src2      = src2_s;
      ex_nxt_s.pc        = pc_in;
    end else begin
      ex_nxt_s = '0;
    end
  end

  // ID/EX pipeline register; freeze holds it regardless of flush or hazards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r <= '0;
    end else if (!freeze) begin
      ex_r <= ex_nxt_s;
    end
  end

  assign ex_valid     = ex_r.valid;
  assign ex_wb_en     = ex_r.wb_en;
  assign ex_mem_read  = ex_r.mem_read;
  assign ex_mem_write = ex_r.mem_write;
  assign ex_s         = ex_r.s;
  assign ex_branch    = ex_r.branch;
  assign ex_imm       = ex_r.imm;
  assign ex_cmd       = ex_r.cmd;
  assign ex_val_rn    = ex_r.val_rn;
  assign ex_val_rm    = ex_r.val_rm;
  assign ex_shift_op  = ex_r.shift_op;
  assign ex_simm24    = ex_r.simm24;
  assign ex_dest      = ex_r.dest;
  assign ex_src1      = ex_r.src1;
  assign ex_src2      = ex_r.src2;
  assign ex_pc        = ex_r.pc;

  id_stage_pipelined_chk #(.HAZARD_EN(HAZARD_EN)) u_chk (
    .clk          (clk),
    .rst          (rst),
    .hazard_stall (hazard_s),
    .ex_valid     (ex_r.valid),
    .ex_wb_en     (ex_r.wb_en),
    .ex_mem_read  (ex_r.mem_read),
    .ex_mem_write (ex_r.mem_write),
    .ex_s         (ex_r.s),
    .ex_branch    (ex_r.branch)
  );

endmodule

// Structural invariants of the ID/EX register outputs.
module id_stage_pipelined_chk #(
  parameter bit HAZARD_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  input logic hazard_stall,
  input logic ex_valid,
  input logic ex_wb_en,
  input logic ex_mem_read,
  input logic ex_mem_write,
  input logic ex_s,
  input logic ex_branch
);

  // Sample invariants on every rising edge outside reset.
  always @(posedge clk) begin
    if (!rst) begin
      assert (ex_valid || !(ex_wb_en || ex_mem_read || ex_mem_write || ex_s || ex_branch));
      assert (!(ex_mem_read && ex_mem_write));
      assert (!ex_branch || !(ex_wb_en || ex_mem_read || ex_mem_write || ex_s));
      assert (HAZARD_EN || !hazard_stall);
    end
  end

endmodule
